// File: rtl/ctrl_pipe_decoder.sv
// ctrl_pipe_decoder: registered control decoder for the 4-bit opcode ISA.
// It decodes through one pipeline slot, stalls fetch on load-use hazards,
// flushes after a taken branch, latches program completion (Ack) and
// counts decoded instructions with saturation.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal decode; branch, hazard stall and Ack detection
// ST_FLUSH | wrong-path instructions dropped, bubbles loaded
// ST_DONE  | program finished, Ack held, inputs ignored until Reset
module ctrl_pipe_decoder #(
  parameter int INSTR_W      = 9,
  parameter int OP_W         = 4,
  parameter int REG_W        = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [INSTR_W-1:0] Instruction,
  input  logic               InstrValid,
  input  logic               BranchTaken,
  output logic               Stall,
  output logic               DecValid,
  output logic               BranchEn,
  output logic               RegWrEn,
  output logic               MemWrEn,
  output logic               ALUEn,
  output logic               LUTdm,
  output logic               Jump,
  output logic               SetInst,
  output logic               Ack,
  output logic [OP_W-1:0]    OpcodeQ,
  output logic [REG_W-1:0]   RegFieldQ,
  output logic [CNT_W-1:0]   InstrCount
);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_DONE} state_t;

  localparam logic [OP_W-1:0] OP_LW  = OP_W'(4'b0000);
  localparam logic [OP_W-1:0] OP_LWL = OP_W'(4'b0001);
  localparam logic [2:0]      FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  // strobe vector order: {BranchEn, RegWrEn, MemWrEn, ALUEn, LUTdm, Jump, SetInst}
  localparam logic [6:0] S_RW   = 7'b0100000;
  localparam logic [6:0] S_RWL  = 7'b0100100;
  localparam logic [6:0] S_MWL  = 7'b0010100;
  localparam logic [6:0] S_MW   = 7'b0010000;
  localparam logic [6:0] S_ALU  = 7'b0101000;
  localparam logic [6:0] S_SET  = 7'b0101011;
  localparam logic [6:0] S_BR   = 7'b1000000;

  state_t             r_state;
  logic [2:0]         r_flush_cnt;
  logic               r_dec_valid;
  logic [6:0]         r_strb;
  logic               r_ack;
  logic [OP_W-1:0]    r_op;
  logic [REG_W-1:0]   r_field;
  logic [CNT_W-1:0]   r_cnt;

  logic [OP_W-1:0]    w_op;
  logic [REG_W-1:0]   w_field;
  logic [6:0]         w_dec;
  logic               w_is_ack;
  logic               w_hazard;

  assign w_op     = Instruction[INSTR_W-1 -: OP_W];
  assign w_field  = Instruction[REG_W-1:0];
  assign w_is_ack = &Instruction;

  // Opcode to control strobes; 1111 (illegal or Ack) drives no strobes.
  always_comb begin
    w_dec = '0;
    case (w_op)
      OP_W'(4'b0000): w_dec = S_RW;
      OP_W'(4'b0001): w_dec = S_RWL;
      OP_W'(4'b0010): w_dec = S_MWL;
      OP_W'(4'b0011): w_dec = S_MW;
      OP_W'(4'b0100),
      OP_W'(4'b0101),
      OP_W'(4'b0110),
      OP_W'(4'b0111),
      OP_W'(4'b1110): w_dec = S_ALU;
      OP_W'(4'b1000): w_dec = S_RW;
      OP_W'(4'b1001),
      OP_W'(4'b1010): w_dec = S_SET;
      OP_W'(4'b1011),
      OP_W'(4'b1101): w_dec = S_BR;
      OP_W'(4'b1100): w_dec = S_RWL;
      default:        w_dec = '0;
    endcase
  end

  // A load in the slot feeding an ALU op that reads the same register.
  assign w_hazard = InstrValid && r_dec_valid && ((r_op == OP_LW) || (r_op == OP_LWL))
                    && w_dec[3] && (w_field == r_field);

  // Branch outranks the hazard, so a squashed instruction never stalls fetch.
  assign Stall = !Reset && (r_state == ST_RUN) && !BranchTaken && w_hazard;

  // Pipeline slot, FSM, flush counter and instruction counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
      r_dec_valid <= 1'b0;
      r_strb      <= '0;
      r_ack       <= 1'b0;
      r_op        <= '0;
      r_field     <= '0;
      r_cnt       <= '0;
    end else begin
      r_dec_valid <= 1'b0;
      r_strb      <= '0;
      r_ack       <= 1'b0;
      r_op        <= '0;
      r_field     <= '0;
      case (r_state)
        ST_RUN: begin
          if (BranchTaken) begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= FLUSH_INIT;
          end else if (w_hazard) begin
            r_state <= ST_RUN;
          end else if (InstrValid) begin
            r_dec_valid <= 1'b1;
            r_op        <= w_op;
            r_field     <= w_field;
            if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
            if (w_is_ack) begin
              r_ack   <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_strb <= w_dec;
            end
          end
        end
        ST_FLUSH: begin
          if (BranchTaken)              r_flush_cnt <= FLUSH_INIT;
          else if (r_flush_cnt == 3'd0) r_state     <= ST_RUN;
          else                          r_flush_cnt <= r_flush_cnt - 3'd1;
        end
        ST_DONE: r_ack   <= 1'b1;
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign DecValid   = r_dec_valid;
  assign BranchEn   = r_strb[6];
  assign RegWrEn    = r_strb[5];
  assign MemWrEn    = r_strb[4];
  assign ALUEn      = r_strb[3];
  assign LUTdm      = r_strb[2];
  assign Jump       = r_strb[1];
  assign SetInst    = r_strb[0];
  assign Ack        = r_ack;
  assign OpcodeQ    = r_op;
  assign RegFieldQ  = r_field;
  assign InstrCount = r_cnt;

endmodule

// File: tb/tb_ctrl_pipe_decoder.sv
// Directed bench for ctrl_pipe_decoder (FLUSH_CYCLES=2, CNT_W=4).
module tb_ctrl_pipe_decoder;
  localparam int INSTR_W = 9, OP_W = 4, REG_W = 3, FLUSH_CYCLES = 2, CNT_W = 4;

  // expected strobe vectors {BranchEn, RegWrEn, MemWrEn, ALUEn, LUTdm, Jump, SetInst}
  localparam logic [6:0] S_NONE = 7'b0000000;
  localparam logic [6:0] S_RW   = 7'b0100000;
  localparam logic [6:0] S_ALU  = 7'b0101000;
  localparam logic [6:0] S_BR   = 7'b1000000;

  logic               Clk = 1'b0;
  logic               Reset;
  logic [INSTR_W-1:0] Instruction;
  logic               InstrValid;
  logic               BranchTaken;
  logic               Stall, DecValid, BranchEn, RegWrEn, MemWrEn, ALUEn, LUTdm, Jump, SetInst, Ack;
  logic [OP_W-1:0]    OpcodeQ;
  logic [REG_W-1:0]   RegFieldQ;
  logic [CNT_W-1:0]   InstrCount;
  logic [6:0]         w_strb;

  int n_run  = 0;
  int n_fail = 0;

  ctrl_pipe_decoder #(
    .INSTR_W(INSTR_W), .OP_W(OP_W), .REG_W(REG_W),
    .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .InstrValid(InstrValid),
    .BranchTaken(BranchTaken), .Stall(Stall), .DecValid(DecValid), .BranchEn(BranchEn),
    .RegWrEn(RegWrEn), .MemWrEn(MemWrEn), .ALUEn(ALUEn), .LUTdm(LUTdm), .Jump(Jump),
    .SetInst(SetInst), .Ack(Ack), .OpcodeQ(OpcodeQ), .RegFieldQ(RegFieldQ),
    .InstrCount(InstrCount)
  );

  assign w_strb = {BranchEn, RegWrEn, MemWrEn, ALUEn, LUTdm, Jump, SetInst};

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] mk(input logic [3:0] op, input logic [2:0] fld);
    return {op, 2'b00, fld};
  endfunction

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [8:0] ins, input logic bt);
    InstrValid  = v;
    Instruction = ins;
    BranchTaken = bt;
  endtask

  task automatic do_reset;
    Reset = 1'b1;
    drive(1'b0, 9'h000, 1'b0);
    tick;
    Reset = 1'b0;
  endtask

  // checks one decoded slot: valid, strobes, opcode, field
  task automatic slot(input string tag, input logic v, input logic [6:0] s,
                      input logic [3:0] op, input logic [2:0] fld);
    check({tag, ".valid"}, 32'(DecValid), 32'(v));
    check({tag, ".strb"},  32'(w_strb),   32'(s));
    check({tag, ".op"},    32'(OpcodeQ),  32'(op));
    check({tag, ".fld"},   32'(RegFieldQ), 32'(fld));
  endtask

  logic [3:0] cnt_hold;

  initial begin
    Reset = 1'b1;
    drive(1'b0, 9'h000, 1'b0);
    tick; tick;
    Reset = 1'b0;
    slot("rst", 1'b0, S_NONE, 4'h0, 3'd0);
    check("rst.ack", 32'(Ack), 32'd0);
    check("rst.cnt", 32'(InstrCount), 32'd0);
    check("rst.stall", 32'(Stall), 32'd0);

    // add, xor, mov stream
    drive(1'b1, 9'b0101_0000_1, 1'b0); tick;
    slot("add", 1'b1, S_ALU, 4'h5, 3'd1);
    drive(1'b1, mk(4'b0100, 3'd2), 1'b0); tick;
    slot("xor", 1'b1, S_ALU, 4'h4, 3'd2);
    drive(1'b1, mk(4'b1000, 3'd5), 1'b0); tick;
    slot("mov", 1'b1, S_RW, 4'h8, 3'd5);
    drive(1'b0, 9'h000, 1'b0); tick;
    slot("idle", 1'b0, S_NONE, 4'h0, 3'd0);
    check("stream.cnt", 32'(InstrCount), 32'd3);

    // load-use hazard: lw r3 then add r3
    do_reset;
    drive(1'b1, mk(4'b0000, 3'd3), 1'b0); tick;
    slot("lw", 1'b1, S_RW, 4'h0, 3'd3);
    drive(1'b1, mk(4'b0101, 3'd3), 1'b0); #1;
    check("haz.stall", 32'(Stall), 32'd1);
    tick;
    slot("haz.bubble", 1'b0, S_NONE, 4'h0, 3'd0);
    check("haz.stall_clr", 32'(Stall), 32'd0);
    tick;
    slot("haz.add", 1'b1, S_ALU, 4'h5, 3'd3);
    check("haz.cnt", 32'(InstrCount), 32'd2);

    // same sequence with a different field: no stall
    drive(1'b1, mk(4'b0000, 3'd3), 1'b0); tick;
    drive(1'b1, mk(4'b0101, 3'd2), 1'b0); #1;
    check("nohaz.stall", 32'(Stall), 32'd0);
    tick;
    slot("nohaz.add", 1'b1, S_ALU, 4'h5, 3'd2);

    // illegal op: counted valid slot with no strobes
    drive(1'b1, 9'b1111_0000_0, 1'b0); tick;
    slot("illegal", 1'b1, S_NONE, 4'hF, 3'd0);
    check("illegal.ack", 32'(Ack), 32'd0);

    // hazard coinciding with a taken branch: branch wins, no stall
    do_reset;
    drive(1'b1, mk(4'b0000, 3'd3), 1'b0); tick;
    drive(1'b1, mk(4'b0101, 3'd3), 1'b1); #1;
    check("hazbr.stall", 32'(Stall), 32'd0);
    tick;
    slot("hazbr.b0", 1'b0, S_NONE, 4'h0, 3'd0);
    drive(1'b1, mk(4'b0101, 3'd3), 1'b0); #1;
    check("hazbr.flush_nostall", 32'(Stall), 32'd0);
    tick; tick;
    drive(1'b1, mk(4'b1000, 3'd1), 1'b0); tick;
    slot("hazbr.resume", 1'b1, S_RW, 4'h8, 3'd1);

    // branch flush: squash bubble at the branch edge, then FLUSH_CYCLES bubbles
    do_reset;
    drive(1'b1, mk(4'b1101, 3'd0), 1'b0); tick;
    slot("bol", 1'b1, S_BR, 4'hD, 3'd0);
    drive(1'b1, mk(4'b0101, 3'd1), 1'b1); tick;
    slot("fl.b0", 1'b0, S_NONE, 4'h0, 3'd0);
    drive(1'b1, mk(4'b0101, 3'd2), 1'b0); tick;
    slot("fl.b1", 1'b0, S_NONE, 4'h0, 3'd0);
    drive(1'b1, mk(4'b0101, 3'd3), 1'b0); tick;
    slot("fl.b2", 1'b0, S_NONE, 4'h0, 3'd0);
    drive(1'b1, mk(4'b1000, 3'd4), 1'b0); tick;
    slot("fl.resume", 1'b1, S_RW, 4'h8, 3'd4);
    check("fl.cnt", 32'(InstrCount), 32'd2);

    // second branch in the first flush bubble reloads the counter
    drive(1'b1, mk(4'b0101, 3'd1), 1'b1); tick;
    slot("rl.b0", 1'b0, S_NONE, 4'h0, 3'd0);
    drive(1'b1, mk(4'b0101, 3'd2), 1'b1); tick;
    slot("rl.b1", 1'b0, S_NONE, 4'h0, 3'd0);
    drive(1'b1, mk(4'b0101, 3'd3), 1'b0); tick;
    slot("rl.b2", 1'b0, S_NONE, 4'h0, 3'd0);
    drive(1'b1, mk(4'b0101, 3'd4), 1'b0); tick;
    slot("rl.b3", 1'b0, S_NONE, 4'h0, 3'd0);
    drive(1'b1, mk(4'b1000, 3'd6), 1'b0); tick;
    slot("rl.resume", 1'b1, S_RW, 4'h8, 3'd6);

    // Ack: all-ones instruction, sticky through random stimulus
    do_reset;
    drive(1'b1, 9'h1FF, 1'b0); tick;
    check("ack.ack", 32'(Ack), 32'd1);
    slot("ack.slot", 1'b1, S_NONE, 4'hF, 3'd7);
    check("ack.cnt", 32'(InstrCount), 32'd1);
    for (int i = 0; i < 10; i++) begin
      drive(1'($urandom_range(1)), 9'($urandom), 1'($urandom_range(1)));
      #1;
      check("done.stall", 32'(Stall), 32'd0);
      tick;
      check("done.ack", 32'(Ack), 32'd1);
      check("done.valid", 32'(DecValid), 32'd0);
      check("done.strb", 32'(w_strb), 32'(S_NONE));
      check("done.cnt", 32'(InstrCount), 32'd1);
    end
    do_reset;
    check("rst_done.ack", 32'(Ack), 32'd0);
    check("rst_done.cnt", 32'(InstrCount), 32'd0);
    drive(1'b1, mk(4'b0101, 3'd1), 1'b0); tick;
    slot("rst_done.run", 1'b1, S_ALU, 4'h5, 3'd1);

    // saturation at 4'hF
    do_reset;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, mk(4'b1000, 3'd0), 1'b0);
      tick;
      if (i == 14) cnt_hold = InstrCount;
    end
    check("sat.at15", 32'(cnt_hold), 32'd15);
    check("sat.cnt", 32'(InstrCount), 32'd15);
    drive(1'b0, 9'h000, 1'b0); tick;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ctrl_pipe_decoder.md
Name: ctrl_pipe_decoder

Overview:
Parametrised, registered successor to the combinational control decoder. It decodes the 4-bit opcode ISA into the same control strobes through one pipeline register, and detects load-use hazards to stall fetch. It also flushes for a configurable number of cycles after a taken branch, latches program completion (Ack) in a terminal state, and counts decoded instructions. It sits between instruction ROM/fetch and the datapath (reg_file, ALU, data_mem, LUT).

Parameters:
INSTR_W, 9, instruction width; opcode is Instruction[INSTR_W-1 -: OP_W]
OP_W, 4, opcode width
REG_W, 3, register field width; field is Instruction[REG_W-1:0]
FLUSH_CYCLES, 1, bubbles inserted after BranchTaken (1..7)
CNT_W, 16, InstrCount width

Ports:
Clk  in  1  clock, all state on rising edge
Reset  in  1  synchronous, active-high
Instruction  in  INSTR_W  instruction from fetch
InstrValid  in  1  Instruction is meaningful this cycle
BranchTaken  in  1  branch resolved taken (from ALU flags/execute)
Stall  out  1  combinational; fetch must hold PC and Instruction
DecValid  out  1  registered; decoded slot holds a real instruction
BranchEn, RegWrEn, MemWrEn, ALUEn, LUTdm, Jump, SetInst  out  1 each  registered control strobes
Ack  out  1  registered; program done, sticky
OpcodeQ  out  OP_W  registered opcode of decoded slot
RegFieldQ  out  REG_W  registered register field of decoded slot
InstrCount  out  CNT_W  decoded-instruction counter, saturating

Behaviour:
- Reset (synchronous, highest priority): all outputs 0, state RUN, flush counter 0, InstrCount 0. A Reset asserted mid-stall, mid-flush or in DONE returns to RUN on the next edge.
- Decode table (opcode -> strobes set; all others 0):
  0000 lw: RegWrEn
  0001 lwl: RegWrEn, LUTdm
  0010 sw: MemWrEn, LUTdm
  0011 swl: MemWrEn
  0100 xor, 0101 add, 0110 lsr, 0111 lsl, 1110 msk: ALUEn, RegWrEn
  1000 mov: RegWrEn
  1001 sne, 1010 seq: ALUEn, RegWrEn, Jump, SetInst
  1011 boo, 1101 bol: BranchEn
  1100 lut: RegWrEn, LUTdm
  1111 with non-all-ones operand: illegal, all strobes 0 but DecValid=1
- Ack: the all-ones Instruction decodes to Ack. Latency is 1 cycle. All other strobes are 0 in that slot.
- Latency: an accepted instruction appears on the registered outputs one cycle later.
- Bubble: DecValid=0, all strobes 0, OpcodeQ/RegFieldQ=0.
- FSM states: RUN, FLUSH, DONE.
- RUN:
  - BranchTaken=1: next state FLUSH, counter=FLUSH_CYCLES-1, bubble loaded. Branch has priority over stall and over an incoming Ack.
  - Otherwise, load-use hazard: the registered slot is lw/lwl (DecValid=1), InstrValid=1, the incoming opcode is ALU-using, and the incoming field equals RegFieldQ. Then Stall=1 and a bubble is loaded. The held instruction decodes next cycle, so a hazard costs exactly 1 stall cycle.
  - Otherwise, InstrValid=1: decode into the slot. If it is Ack, next state DONE.
  - Otherwise (InstrValid=0): bubble.
- FLUSH:
  - Each cycle a bubble is loaded and the incoming instruction is discarded; Stall=0.
  - At counter 0, return to RUN; otherwise decrement.
  - BranchTaken during FLUSH reloads the counter.
- DONE:
  - Ack=1 held, all strobes 0, DecValid=0, Stall=0.
  - InstrCount frozen; Instruction and BranchTaken are ignored.
  - Exit only via Reset.
- InstrCount: +1 on every edge that loads DecValid=1 (including the Ack and illegal slots). Saturates at all-ones with no wrap.
- Stall is never asserted in FLUSH or DONE, nor when InstrValid=0.

Test Plan:
- Reset, then stream add (0101_0000_1), xor, mov with InstrValid=1 -> one cycle later ALUEn=1 and RegWrEn=1 for add/xor; mov gives RegWrEn only. InstrCount=3.
- lw with field 3, then add with field 3 -> Stall=1 for 1 cycle and a DecValid=0 bubble; add decodes on the following cycle. The same sequence with add field 2 -> no stall.
- FLUSH_CYCLES=2: BranchTaken pulse after bol -> 2 bubbles, the two incoming instructions are dropped, the third decodes. A second BranchTaken in the first bubble cycle -> 2 further bubbles.
- Instruction 9'h1FF -> Ack=1 next cycle and it stays high through 10 cycles of random stimulus; InstrCount is unchanged. Reset -> Ack=0 and RUN.
- Force InstrCount near saturation (CNT_W=4, 17 valid instructions) -> stops at 15.
- lw + hazard add coinciding with BranchTaken -> no Stall, flush taken. The 1111_0000_0 illegal op -> DecValid=1 with all strobes 0.
